// File: rtl/ysyx_22041071_fetch_queue_pkg.sv
// rtl/ysyx_22041071_fetch_queue_pkg.sv - shared constants for the fetch stage and its queue
package ysyx_22041071_fetch_queue_pkg;

    localparam logic [31:0] NOP_INS      = 32'h0000_0013;
    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
    localparam logic [63:0] DEF_RAM_BASE = 64'h8000_0000;

    // Queue entry is packed as {fault, pc, ins}; snpc is rebuilt from pc at the output.
    function automatic int entry_width(input int addr_w, input int ins_w);
        return addr_w + ins_w + 1;
    endfunction

endpackage

// File: rtl/ysyx_22041071_sync_fifo.sv
// rtl/ysyx_22041071_sync_fifo.sv - synchronous FIFO with flush and show-ahead head
module ysyx_22041071_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ysyx_22041071_fetch_queue.sv
// rtl/ysyx_22041071_fetch_queue.sv - instruction fetch controller feeding ID through a fetch queue
module ysyx_22041071_fetch_queue
    import ysyx_22041071_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                INS_W    = 32,
    parameter int                FETCH_W  = 64,
    parameter int                FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(DEF_RAM_BASE),
    parameter int                NUM_BUB  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_vld,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic [NUM_BUB-1:0]  bubble,
    output logic                imem_en,
    output logic [ADDR_W-1:0]   imem_idx,
    input  logic [FETCH_W-1:0]  imem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [INS_W-1:0]    out_ins,
    output logic [ADDR_W-1:0]   out_snpc,
    output logic                out_fault
);
    localparam int OFF_W = $clog2(FETCH_W / 8);
    localparam int RATIO = FETCH_W / INS_W;
    localparam int EW    = entry_width(ADDR_W, INS_W);
    localparam int CW    = $clog2(FQ_DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              inflight_epoch;
    logic              epoch;
    logic              halted;

    logic [CW-1:0]     fq_count;
    logic              fq_full;
    logic              fq_empty;
    logic [EW-1:0]     head;
    logic [EW-1:0]     push_data;
    logic              credit, aligned, issue, resp_push, fault_push, fq_push, fq_pop, any_bubble;
    logic [ADDR_W-1:0] sel;
    logic [INS_W-1:0]  resp_ins;

    // Queued entries plus the outstanding read must never exceed the queue size.
    assign credit     = ({1'b0, fq_count} + (CW+1)'(inflight)) < (CW+1)'(FQ_DEPTH);
    assign aligned    = (fetch_pc[1:0] == 2'b00);
    assign issue      = reset && !redirect_vld && !halted && aligned && credit;
    assign resp_push  = inflight && (inflight_epoch == epoch);
    assign fault_push = reset && !redirect_vld && !halted && !aligned && credit && !resp_push && !fq_full;
    assign fq_push    = resp_push || fault_push;
    assign any_bubble = |bubble;
    assign fq_pop     = reset && out_ready && !any_bubble;

    assign imem_en  = issue;
    assign imem_idx = (fetch_pc - RAM_BASE) >> OFF_W;

    assign sel = (inflight_pc >> 2) & ADDR_W'(RATIO - 1);

    always_comb begin
        resp_ins = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (sel == ADDR_W'(i)) resp_ins = imem_rdata[i*INS_W +: INS_W];
        end
    end

    assign push_data = fault_push ? {1'b1, fetch_pc, {INS_W{1'b0}}}
                                  : {1'b0, inflight_pc, resp_ins};

    ysyx_22041071_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fq_push),
        .push_data (push_data),
        .pop       (fq_pop),
        .flush     (redirect_vld),
        .head_data (head),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            halted         <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fetch_pc;
                inflight_epoch <= epoch;
            end
            if (redirect_vld) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
                halted   <= 1'b0;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end else if (fault_push) begin
                halted <= 1'b1;
            end
        end
    end

    // A bubble shows a NOP at the head position without consuming the head.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_ins   = '0;
        out_fault = 1'b0;
        if (reset) begin
            if (any_bubble) begin
                out_valid = 1'b1;
                out_pc    = fq_empty ? fetch_pc : head[EW-2 -: ADDR_W];
                out_ins   = INS_W'(NOP_INS);
            end else if (!fq_empty) begin
                out_valid = 1'b1;
                out_pc    = head[EW-2 -: ADDR_W];
                out_ins   = head[INS_W-1:0];
                out_fault = head[EW-1];
            end
        end
        out_snpc = out_valid ? out_pc + ADDR_W'(4) : '0;
    end

endmodule

// File: tb/tb_ysyx_22041071_fetch_queue.sv
// tb/tb_ysyx_22041071_fetch_queue.sv - vector table plus randomized stream check for the fetch queue
module tb_ysyx_22041071_fetch_queue;

    localparam logic [63:0] B   = 64'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_vld = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [2:0]  bubble = '0;
    logic        imem_en;
    logic [63:0] imem_idx;
    logic [63:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_ins;
    logic [63:0] out_snpc;
    logic        out_fault;

    int n_cmp = 0;
    int n_bad = 0;

    ysyx_22041071_fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .bubble       (bubble),
        .imem_en      (imem_en),
        .imem_idx     (imem_idx),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_ins      (out_ins),
        .out_snpc     (out_snpc),
        .out_fault    (out_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [63:0] a);
        if (a == B)             return 32'h11;
        else if (a == B + 64'd4) return 32'h22;
        else                    return 32'hA500_0000 ^ a[31:0];
    endfunction

    function automatic logic [63:0] word_of(input logic [63:0] idx);
        logic [63:0] a;
        a = B + (idx << 3);
        return {ins_of(a + 64'd4), ins_of(a)};
    endfunction

    // One-cycle-latency instruction RAM
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word_of(imem_idx);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        redir;
        logic [63:0] rpc;
        logic [2:0]  bub;
        logic        rdy;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic        e_fault;
        logic        e_en;
        logic [63:0] e_idx;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic redir, input logic [63:0] rpc,
                                input logic [2:0] bub, input logic rdy, input logic ev,
                                input logic [63:0] epc, input logic [31:0] eins, input logic ef,
                                input logic een, input logic [63:0] eidx);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.bub = bub; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_ins = eins; v.e_fault = ef;
        v.e_en = een; v.e_idx = eidx;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [63:0] exp_pc;
        logic        done;
        logic        mis;
        int          stall;
        logic        rst_now, redir_now, rdy_now;
        logic [2:0]  bub_now;
        logic [63:0] rpc_now;

        // rst redir rpc bub rdy | valid pc ins fault | en idx
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0,0,1, 1,B,32'h11,0, 1,1));
        tbl.push_back(mk(1,0,0,0,1, 1,B+4,32'h22,0, 1,1));
        tbl.push_back(mk(1,0,0,0,0, 1,B+8,ins_of(B+8),0, 1,2));
        tbl.push_back(mk(1,0,0,0,0, 1,B+8,ins_of(B+8),0, 1,2));
        tbl.push_back(mk(1,0,0,0,0, 1,B+8,ins_of(B+8),0, 0,0));
        tbl.push_back(mk(1,0,0,0,0, 1,B+8,ins_of(B+8),0, 0,0));
        tbl.push_back(mk(1,0,0,3'b010,1, 1,B+8,NOP,0, 0,0));
        tbl.push_back(mk(1,0,0,3'b010,1, 1,B+8,NOP,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 1,B+8,ins_of(B+8),0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 1,B+'h0C,ins_of(B+'h0C),0, 1,3));
        tbl.push_back(mk(1,0,0,0,1, 1,B+'h10,ins_of(B+'h10),0, 1,3));
        tbl.push_back(mk(1,0,0,0,0, 1,B+'h14,ins_of(B+'h14),0, 1,4));
        tbl.push_back(mk(1,1,B+'h100,0,0, 1,B+'h14,ins_of(B+'h14),0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 1,'h20));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 1,'h20));
        tbl.push_back(mk(1,0,0,0,1, 1,B+'h100,ins_of(B+'h100),0, 1,'h21));
        tbl.push_back(mk(1,0,0,0,1, 1,B+'h104,ins_of(B+'h104),0, 1,'h21));
        tbl.push_back(mk(1,1,B+'h102,0,1, 1,B+'h108,ins_of(B+'h108),0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 1,B+'h102,0,1, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,1,B+'h200,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 1,'h40));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 1,'h40));
        tbl.push_back(mk(1,0,0,0,0, 1,B+'h200,ins_of(B+'h200),0, 1,'h41));
        tbl.push_back(mk(1,0,0,0,0, 1,B+'h200,ins_of(B+'h200),0, 1,'h41));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0, 1,0));
        tbl.push_back(mk(1,0,0,0,1, 1,B,32'h11,0, 1,1));

        foreach (tbl[k]) begin
            @(negedge clk);
            reset        = tbl[k].rst;
            redirect_vld = tbl[k].redir;
            redirect_pc  = tbl[k].rpc;
            bubble       = tbl[k].bub;
            out_ready    = tbl[k].rdy;
            #1;
            chk($sformatf("vec%0d imem_en", k), 64'(imem_en), 64'(tbl[k].e_en));
            if (tbl[k].e_en) chk($sformatf("vec%0d imem_idx", k), imem_idx, tbl[k].e_idx);
            chk($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'(tbl[k].e_valid));
            if (tbl[k].e_valid) begin
                chk($sformatf("vec%0d out_pc", k), out_pc, tbl[k].e_pc);
                chk($sformatf("vec%0d out_ins", k), 64'(out_ins), 64'(tbl[k].e_ins));
                chk($sformatf("vec%0d out_fault", k), 64'(out_fault), 64'(tbl[k].e_fault));
                chk($sformatf("vec%0d out_snpc", k), out_snpc, tbl[k].e_pc + 64'd4);
            end
        end

        // Randomized phase: the model only tracks the architectural stream of accepted entries.
        @(negedge clk);
        reset = 1'b0; redirect_vld = 1'b0; bubble = '0; out_ready = 1'b0;
        exp_pc = B;
        done   = 1'b0;
        stall  = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_now   = ($urandom_range(0, 299) == 0);
            redir_now = !rst_now && ($urandom_range(0, 31) == 0);
            rpc_now   = B + (64'($urandom_range(0, 900)) << 2)
                          + (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd0);
            bub_now   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rdy_now   = ($urandom_range(0, 3) != 0);
            reset        = !rst_now;
            redirect_vld = redir_now;
            redirect_pc  = rpc_now;
            bubble       = bub_now;
            out_ready    = rdy_now;
            #1;
            mis = (exp_pc[1:0] != 2'b00);
            if (rst_now) begin
                chk("rnd reset out_valid", 64'(out_valid), 64'd0);
                chk("rnd reset imem_en", 64'(imem_en), 64'd0);
            end else if (bub_now != 3'd0) begin
                chk("rnd bubble out_valid", 64'(out_valid), 64'd1);
                chk("rnd bubble out_ins", 64'(out_ins), 64'(NOP));
                chk("rnd bubble out_fault", 64'(out_fault), 64'd0);
            end else if (done) begin
                chk("rnd halted out_valid", 64'(out_valid), 64'd0);
                if (!redir_now) chk("rnd halted imem_en", 64'(imem_en), 64'd0);
            end else if (out_valid) begin
                chk("rnd out_pc", out_pc, exp_pc);
                chk("rnd out_ins", 64'(out_ins), mis ? 64'd0 : 64'(ins_of(exp_pc)));
                chk("rnd out_fault", 64'(out_fault), 64'(mis));
                chk("rnd out_snpc", out_snpc, exp_pc + 64'd4);
            end

            if (!rst_now && !redir_now && bub_now == 3'd0 && rdy_now && !done && !out_valid)
                stall++;
            else
                stall = 0;
            chk("rnd liveness stall>4", 64'(stall > 4), 64'd0);

            if (rst_now) begin
                exp_pc = B;
                done   = 1'b0;
            end else if (redir_now) begin
                exp_pc = rpc_now;
                done   = 1'b0;
            end else if (bub_now == 3'd0 && rdy_now && out_valid && !done) begin
                if (mis) done = 1'b1;
                else     exp_pc = exp_pc + 64'd4;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
